buzzer_arbiter: RTL and testbench
=================================

Name: buzzer_arbiter

Overview:
Shares the single buzzer/key output between the piano's note sources: free-play keyboard, autoplay, and learning mode. Requesters are resolved by fixed priority (round-robin optional). Two timing rules avoid chatter and clicks:
- Every granted note sounds for at least MIN_HOLD cycles.
- Every change of owner inserts GAP_CYCLES cycles of silence.
Sits between the mode blocks and the buzzer tone generator.

Parameters:
NUM_REQ, 3, number of requesters; index 0 is highest priority.
MIN_HOLD, 5000000, minimum key_on cycles per grant (50 ms at 100 MHz); must be >=1.
GAP_CYCLES, 1000000, silent cycles between grants; must be >=1.
CNT_W, 26, width of the hold and gap counters; must hold max(MIN_HOLD, GAP_CYCLES).

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
req  input  NUM_REQ  per-requester request level
req_key  input  4*NUM_REQ  note value of requester i at bits [4i+3:4i]
enable_mask  input  NUM_REQ  mode gating; requester i is ignored when bit i=0
key_on  output  1  buzzer enable, registered
key  output  4  note value to the tone generator, registered
grant  output  NUM_REQ  one-hot current owner; 0 when no owner
busy  output  1  high whenever state is not IDLE
preempt  output  1  one-cycle pulse when an owner is displaced by a higher-priority requester

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, key_on=0, key=0, grant=0, busy=0, preempt=0, counters=0. This applies mid-PLAY or mid-GAP with no partial note or gap completion.
- eff = req & enable_mask, sampled each edge. winner = lowest set index of eff.
- States: IDLE, PLAY, GAP.
- IDLE:
  - Outputs are zero.
  - If eff!=0: go to PLAY, grant=onehot(winner), key_on=1, key=req_key[winner], hold_cnt=0.
  - Latency from a request to key_on is 1 cycle.
- PLAY, owner still in eff:
  - key follows the owner's req_key each cycle (1-cycle registered latency).
  - A note change by the same owner causes no gap and no hold restart.
- PLAY, hold counter:
  - hold_cnt increments each cycle and saturates at MIN_HOLD-1.
  - hold_done = (hold_cnt == MIN_HOLD-1).
- PLAY, owner leaves eff (req or mask dropped):
  - If !hold_done, key is frozen at its last value and key_on stays 1 until hold_done.
  - At hold_done, go to GAP.
- PLAY, a higher-priority index appears in eff:
  - If hold_done, go to GAP and pulse preempt for 1 cycle; otherwise keep playing.
  - When release and preemption occur on the same edge, the exit counts as a preemption (preempt=1).
- Guaranteed minimum: key_on is high for at least MIN_HOLD consecutive cycles per grant.
- GAP:
  - key_on=0, key=0, grant=0; gap_cnt counts from 0.
  - Leave GAP on the edge where gap_cnt==GAP_CYCLES-1. key_on is therefore low for exactly GAP_CYCLES cycles.
  - On leaving GAP: if eff!=0, go directly to PLAY with the new winner (same as the IDLE entry); else go to IDLE.
  - Requests made during GAP are not granted before the gap completes.
- grant is always one-hot or zero. key_on=1 implies grant!=0.
- Counters never wrap; they are cleared on every state entry.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined:
  - The winner search starts at (last_owner+1) mod NUM_REQ; last_owner resets to NUM_REQ-1.
  - Preemption is disabled: PLAY exits only on owner release, and preempt is tied to 0.
- Undefined: fixed priority with preemption as described above.

Test Plan:
Use MIN_HOLD=4, GAP_CYCLES=2, NUM_REQ=3, and mask=3'b111 unless stated.
1. Assert rst with random inputs for 3 cycles, then release with req=0 -> key_on=0, key=0, grant=0, busy=0, preempt=0 throughout.
2. req=3'b010 with key1=5 held at edge 0 -> at cycle 1 key_on=1, key=5, grant=3'b010. Change key1 to 7 -> key=7 one cycle later, key_on never drops.
3. req[1] is the owner (key 5) and req[0] is asserted with key0=9 at owner cycle 2 -> key_on/key=5 hold until 4 cycles are complete, then preempt=1 for 1 cycle, then 2 silent cycles, then grant=3'b001, key=9.
4. req[1] pulsed for exactly one edge -> key_on=1 in cycles 1-4 with key frozen, key_on=0 in cycles 5-6, IDLE and busy=0 from cycle 7.
5. req[1]=1 with enable_mask=3'b101 -> no grant. Clear mask bit 1 while req[1] owns -> behaves as a release (hold, then gap).
6. rst asserted at owner cycle 2 -> all outputs 0 at the next edge. Under ARB_ROUND_ROBIN_EN, req=3'b111 held with releases of the owner -> grant order 001, 010, 100, 001 and preempt stays 0.

Source files
------------

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: shares one buzzer key/key_on output between the piano's note
// sources (free play, autoplay, learning mode). Every grant sounds for at least
// MIN_HOLD cycles and every change of owner is separated by GAP_CYCLES silent
// cycles. Fixed priority (index 0 highest) with preemption by default.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin winner search starting
// after the last owner, with preemption disabled (preempt tied low).
module buzzer_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned MIN_HOLD   = 5000000,
  parameter int unsigned GAP_CYCLES = 1000000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_key,
  input  logic [NUM_REQ-1:0]   enable_mask,
  output logic                 key_on,
  output logic [3:0]           key,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 preempt
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic               key_on_q, key_on_d;
  logic [3:0]         key_q, key_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               preempt_q, preempt_d;

  logic [NUM_REQ-1:0] eff;
  logic               win_valid;
  logic [IdxW-1:0]    win_idx;
  logic               hold_done;
  logic               owner_present;
  logic               higher_pri;
  logic               start_play;

  assign eff       = req & enable_mask;
  assign hold_done = (hold_cnt_q == HoldLast);

  // Owner is still requesting (and still enabled by its mode).
  assign owner_present = eff[owner_q];

`ifdef ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] last_owner_q, last_owner_d;

  // Round-robin winner: first set bit of eff starting just after the last owner.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (int'(last_owner_q) + 1 + i) % NUM_REQ;
      if (!win_valid && eff[idx]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'(idx);
      end
    end
  end

  // Round-robin never displaces an owner.
  assign higher_pri = 1'b0;

  // Last-owner pointer; starts at the top index so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= IdxW'(NUM_REQ - 1);
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  // Remember whoever was just granted.
  always_comb begin
    last_owner_d = last_owner_q;
    if (start_play) begin
      last_owner_d = win_idx;
    end
  end
`else
  // Fixed-priority winner: lowest set index of eff.
  always_comb begin
    win_valid = |eff;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eff[i]) begin
        win_idx = IdxW'(i);
      end
    end
  end

  // Any enabled requester with a better (lower) index than the current owner.
  always_comb begin
    higher_pri = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((i < int'(owner_q)) && eff[i]) begin
        higher_pri = 1'b1;
      end
    end
  end
`endif

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    owner_d    = owner_q;
    key_d      = key_q;
    preempt_d  = 1'b0;
    start_play = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          start_play = 1'b1;
        end
      end
      StPlay: begin
        if (hold_done && (higher_pri || !owner_present)) begin
          // Release and preemption on the same edge count as a preemption.
          state_d   = StGap;
          gap_cnt_d = '0;
          preempt_d = higher_pri;
        end else begin
          if (!hold_done) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
          // A departed owner's note is frozen until the minimum hold elapses.
          if (owner_present) begin
            key_d = req_key[4*int'(owner_q) +: 4];
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          if (win_valid) begin
            start_play = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (start_play) begin
      state_d    = StPlay;
      owner_d    = win_idx;
      hold_cnt_d = '0;
      key_d      = req_key[4*int'(win_idx) +: 4];
    end

    key_on_d = (state_d == StPlay);
    busy_d   = (state_d != StIdle);
    grant_d  = key_on_d ? (NUM_REQ'(1) << owner_d) : '0;
    if (!key_on_d) begin
      key_d = '0;
    end
  end

  // State, counters and registered outputs; synchronous reset abandons any note or gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      owner_q    <= '0;
      key_on_q   <= 1'b0;
      key_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      owner_q    <= owner_d;
      key_on_q   <= key_on_d;
      key_q      <= key_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
    end
  end

  assign key_on  = key_on_q;
  assign key     = key_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Testbench for buzzer_arbiter: directed scenarios followed by random traffic,
// every output compared each cycle against a cycle-level reference model that
// tracks owner, cycles played and silent cycles remaining.
module tb_buzzer_arbiter;

  localparam int N  = 3;
  localparam int MH = 4;
  localparam int GC = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [4*N-1:0] req_key;
  logic [N-1:0]  enable_mask;
  logic          key_on;
  logic [3:0]    key;
  logic [N-1:0]  grant;
  logic          busy;
  logic          preempt;

  int npass  = 0;
  int ntotal = 0;

  // Reference model state
  int       m_owner = -1;  // -1: no owner
  int       m_played = 0;  // key_on cycles shown so far for this grant
  int       m_gap = 0;     // silent cycles still to show, including the current one
  int       m_last = N - 1;
  logic [3:0] m_key = '0;
  bit       m_pre = 1'b0;

  buzzer_arbiter #(
    .NUM_REQ   (N),
    .MIN_HOLD  (MH),
    .GAP_CYCLES(GC),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_key    (req_key),
    .enable_mask(enable_mask),
    .key_on     (key_on),
    .key        (key),
    .grant      (grant),
    .busy       (busy),
    .preempt    (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_winner(input logic [N-1:0] e, input int last);
    int i;
    for (int k = 0; k < N; k++) begin
      i = RR ? (last + 1 + k) % N : k;
      if (e[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_start(input int w, input logic [4*N-1:0] rk);
    m_owner  = w;
    m_played = 1;
    m_key    = rk[4*w +: 4];
    m_last   = w;
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] e, input logic [4*N-1:0] rk);
    int w;
    bit higher;
    bit gone;
    m_pre = 1'b0;
    if (r) begin
      m_owner = -1; m_played = 0; m_gap = 0; m_key = '0; m_last = N - 1;
      return;
    end
    if (m_gap > 0) begin
      if (m_gap == 1) begin
        m_gap = 0;
        w = m_winner(e, m_last);
        if (w >= 0) m_start(w, rk);
      end else begin
        m_gap--;
      end
    end else if (m_owner >= 0) begin
      higher = 1'b0;
      if (!RR) begin
        for (int j = 0; j < m_owner; j++) if (e[j]) higher = 1'b1;
      end
      gone = !e[m_owner];
      if (m_played >= MH && (higher || gone)) begin
        m_owner = -1; m_gap = GC; m_key = '0; m_pre = higher;
      end else begin
        m_played++;
        if (!gone) m_key = rk[4*m_owner +: 4];
      end
    end else begin
      w = m_winner(e, m_last);
      if (w >= 0) m_start(w, rk);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic compare_all();
    check("key_on", 32'(key_on), 32'(m_owner >= 0));
    check("key", 32'(key), 32'(m_key));
    check("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("busy", 32'(busy), 32'((m_owner >= 0) || (m_gap > 0)));
    check("preempt", 32'(preempt), 32'(m_pre));
    check("keyon_has_grant", 32'(key_on && (grant == '0)), 32'd0);
  endtask

  // Apply inputs, take one edge, advance the model, compare just after the edge.
  task automatic tick(input logic r, input logic [N-1:0] rq, input logic [4*N-1:0] rk,
                      input logic [N-1:0] m);
    rst = r; req = rq; req_key = rk; enable_mask = m;
    @(posedge clk);
    model_step(r, rq & m, rk);
    #1;
    compare_all();
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 3'b111);
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] msk;
    logic [4*N-1:0] rk;
    logic [N-1:0] exp_order [4];
    logic [N-1:0] own_bit;
    bit got;
    rst = 1'b1; req = '0; req_key = '0; enable_mask = 3'b111;

    // 1: reset with random inputs, then idle
    for (int i = 0; i < 3; i++) tick(1'b1, N'($urandom), 12'($urandom), N'($urandom));
    quiet(3);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_grant", 32'(grant), 32'd0);

    // 2: grant and same-owner note change
    tick(1'b0, 3'b010, 12'h050, 3'b111);
    check("t2_key_on", 32'(key_on), 32'd1);
    check("t2_key", 32'(key), 32'd5);
    check("t2_grant", 32'(grant), 32'b010);
    tick(1'b0, 3'b010, 12'h070, 3'b111);
    tick(1'b0, 3'b010, 12'h070, 3'b111);
    check("t2_key7", 32'(key), 32'd7);
    check("t2_key_on_held", 32'(key_on), 32'd1);
    quiet(10);

    // 3: preemption after minimum hold
    tick(1'b0, 3'b010, 12'h050, 3'b111);
    tick(1'b0, 3'b010, 12'h050, 3'b111);
    tick(1'b0, 3'b011, 12'h059, 3'b111);
    check("t3_c3_key", 32'(key), 32'd5);
    tick(1'b0, 3'b011, 12'h059, 3'b111);
    check("t3_c4_key_on", 32'(key_on), 32'd1);
    tick(1'b0, 3'b011, 12'h059, 3'b111);
`ifndef ARB_ROUND_ROBIN_EN
    check("t3_preempt", 32'(preempt), 32'd1);
    check("t3_gap1", 32'(key_on), 32'd0);
    tick(1'b0, 3'b011, 12'h059, 3'b111);
    check("t3_preempt_off", 32'(preempt), 32'd0);
    check("t3_gap2", 32'(key_on), 32'd0);
    tick(1'b0, 3'b011, 12'h059, 3'b111);
    check("t3_grant0", 32'(grant), 32'b001);
    check("t3_key9", 32'(key), 32'd9);
`endif
    quiet(12);

    // 4: single-edge pulse -> full hold, gap, idle
    tick(1'b0, 3'b010, 12'h050, 3'b111);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) quiet(1);
      check("t4_key_on", 32'(key_on), 32'(c <= MH));
      check("t4_key", 32'(key), (c <= MH) ? 32'd5 : 32'd0);
      check("t4_busy", 32'(busy), 32'(c <= MH + GC));
    end

    // 5: mask gating
    tick(1'b0, 3'b010, 12'h050, 3'b101);
    check("t5_masked", 32'(grant), 32'd0);
    tick(1'b0, 3'b010, 12'h050, 3'b111);
    tick(1'b0, 3'b010, 12'h060, 3'b101);
    check("t5_mask_hold_key", 32'(key), 32'd5);
    for (int i = 0; i < 6; i++) tick(1'b0, 3'b010, 12'h050, 3'b101);
    check("t5_done", 32'(busy), 32'd0);

    // 6: reset mid-play
    tick(1'b0, 3'b010, 12'h050, 3'b111);
    tick(1'b0, 3'b010, 12'h050, 3'b111);
    tick(1'b1, 3'b010, 12'h050, 3'b111);
    check("t6_rst_key_on", 32'(key_on), 32'd0);
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    quiet(2);

`ifdef ARB_ROUND_ROBIN_EN
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        tick(1'b0, 3'b111, 12'h321, 3'b111);
        got = (grant != '0);
      end
      check("rr_order", 32'(grant), 32'(exp_order[k]));
      check("rr_no_preempt", 32'(preempt), 32'd0);
      own_bit = grant;
      for (int t = 0; t < MH - 1; t++) tick(1'b0, 3'b111, 12'h321, 3'b111);
      tick(1'b0, 3'b111 & ~own_bit, 12'h321, 3'b111);
    end
    quiet(6);
`endif

    // Random traffic
    rq = '0; msk = 3'b111; rk = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom);
      if ($urandom_range(0, 9) == 0) msk = ($urandom_range(0, 1) == 0) ? 3'b111 : N'($urandom);
      if ($urandom_range(0, 2) == 0) rk = 12'($urandom);
      tick(($urandom_range(0, 79) == 0), rq, rk, msk);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
